// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two ALU requesters and alu_arbiter.
// Request operands and control are packed per port: port n sits at [32n+31:32n] / [4n+3:4n].
interface alu_arbiter_if #(
    parameter int CNT_W = 16
);
    logic [1:0]       req_valid_w_i;
    logic [63:0]      req_a_w_i;
    logic [63:0]      req_b_w_i;
    logic [7:0]       req_ctrl_w_i;
    logic [1:0]       req_ready_w_o;
    logic [1:0]       resp_valid_w_o;
    logic [31:0]      resp_res_w_o;
    logic             resp_zero_w_o_h;
    logic             resp_err_w_o_h;
    logic [1:0]       resp_ready_w_i;
    logic             busy_w_o_h;
    logic [CNT_W-1:0] cont_cnt_w_o;
    logic [CNT_W-1:0] op_cnt_w_o;

    modport slave (
        input  req_valid_w_i, req_a_w_i, req_b_w_i, req_ctrl_w_i, resp_ready_w_i,
        output req_ready_w_o, resp_valid_w_o, resp_res_w_o, resp_zero_w_o_h,
               resp_err_w_o_h, busy_w_o_h, cont_cnt_w_o, op_cnt_w_o
    );

    modport master (
        output req_valid_w_i, req_a_w_i, req_b_w_i, req_ctrl_w_i, resp_ready_w_i,
        input  req_ready_w_o, resp_valid_w_o, resp_res_w_o, resp_zero_w_o_h,
               resp_err_w_o_h, busy_w_o_h, cont_cnt_w_o, op_cnt_w_o
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin share of one RV32 ALU between two requesters; optional perf counters under ALU_ARB_PERF_EN.
// Latency: accept at T, resp_valid at T+2; at most one op per 3 clocks.
// Backpressure: response held until the granted port's resp_ready; no new grant meanwhile.
module alu_arbiter #(
    parameter int CNT_W    = 16,
    parameter bit PRIO_RST = 1'b0
) (
    input  logic         clk_w_i,
    input  logic         rst_w_i_l,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state, state_nxt;
    logic        prio;
    logic        grant;
    logic        pick;
    logic        accept;
    logic        resp_done;
    logic [1:0]  req_ready;
    logic [1:0]  resp_valid;
    logic [31:0] op_a, op_b;
    logic [3:0]  op_ctrl;
    logic [31:0] res_q;
    logic        zero_q, err_q;
    logic [31:0] alu_res;
    logic        alu_err;

    // A lone requester wins outright; a tie goes to the priority pointer.
    assign pick = (&bus.req_valid_w_i) ? prio : bus.req_valid_w_i[1];

    always_ff @(posedge clk_w_i or negedge rst_w_i_l) begin
        if (!rst_w_i_l) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        resp_done  = 1'b0;
        req_ready  = 2'b00;
        resp_valid = 2'b00;
        case (state)
            IDLE: begin
                if (|bus.req_valid_w_i) begin
                    accept          = 1'b1;
                    req_ready[pick] = 1'b1;
                    state_nxt       = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                resp_valid[grant] = 1'b1;
                if (bus.resp_ready_w_i[grant]) begin
                    resp_done = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control code is {funct7[5], funct3}; shifts use the whole B operand.
    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (op_ctrl)
            4'b0000: alu_res = op_a + op_b;
            4'b0001: alu_res = op_a << op_b;
            4'b0010: alu_res = {31'b0, $signed(op_a) < $signed(op_b)};
            4'b0011: alu_res = {31'b0, op_a < op_b};
            4'b0100: alu_res = op_a ^ op_b;
            4'b0101: alu_res = op_a >> op_b;
            4'b0110: alu_res = op_a | op_b;
            4'b0111: alu_res = op_a & op_b;
            4'b1000: alu_res = op_a - op_b;
            4'b1101: alu_res = $signed(op_a) >>> op_b;
            default: alu_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk_w_i or negedge rst_w_i_l) begin
        if (!rst_w_i_l) begin
            prio    <= PRIO_RST;
            grant   <= 1'b0;
            op_a    <= '0;
            op_b    <= '0;
            op_ctrl <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                grant   <= pick;
                op_a    <= pick ? bus.req_a_w_i[63:32]   : bus.req_a_w_i[31:0];
                op_b    <= pick ? bus.req_b_w_i[63:32]   : bus.req_b_w_i[31:0];
                op_ctrl <= pick ? bus.req_ctrl_w_i[7:4]  : bus.req_ctrl_w_i[3:0];
            end
            if (state == EXEC) begin
                res_q  <= alu_res;
                zero_q <= (alu_res == 32'd0);
                err_q  <= alu_err;
            end
            if (resp_done) prio <= ~grant;
        end
    end

    assign bus.req_ready_w_o   = req_ready;
    assign bus.resp_valid_w_o  = resp_valid;
    assign bus.resp_res_w_o    = res_q;
    assign bus.resp_zero_w_o_h = zero_q;
    assign bus.resp_err_w_o_h  = err_q;
    assign bus.busy_w_o_h      = (state != IDLE);

`ifdef ALU_ARB_PERF_EN
    logic [CNT_W-1:0] cont_cnt, op_cnt;

    always_ff @(posedge clk_w_i or negedge rst_w_i_l) begin
        if (!rst_w_i_l) begin
            cont_cnt <= '0;
            op_cnt   <= '0;
        end else begin
            if ((&bus.req_valid_w_i) && (req_ready != 2'b11) && !(&cont_cnt))
                cont_cnt <= cont_cnt + 1'b1;
            if (resp_done && !(&op_cnt))
                op_cnt <= op_cnt + 1'b1;
        end
    end

    assign bus.cont_cnt_w_o = cont_cnt;
    assign bus.op_cnt_w_o   = op_cnt;
`else
    assign bus.cont_cnt_w_o = {CNT_W{1'b0}};
    assign bus.op_cnt_w_o   = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: stimulus pushes expected responses, a negedge monitor pops and compares.
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    alu_arbiter_if #(.CNT_W(16)) bus ();

    alu_arbiter #(.CNT_W(16), .PRIO_RST(1'b0)) dut (
        .clk_w_i   (clk),
        .rst_w_i_l (rst_n),
        .bus       (bus)
    );

    typedef struct {
        int          port;
        logic [31:0] res;
        logic        zero;
        logic        err;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;

    localparam logic [3:0] C_ADD = 4'b0000, C_SLL = 4'b0001, C_SLT = 4'b0010,
                           C_SLTU = 4'b0011, C_XOR = 4'b0100, C_SRL = 4'b0101,
                           C_OR = 4'b0110, C_AND = 4'b0111, C_SUB = 4'b1000,
                           C_SRA = 4'b1101;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Response monitor: a handshake is visible at the negedge before the consuming edge.
    always @(negedge clk) begin
        if (rst_n && ((bus.resp_valid_w_o & bus.resp_ready_w_i) != 2'b00)) begin
            if (sbq.size() == 0) begin
                chk("unexpected_resp", {30'b0, bus.resp_valid_w_o}, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("resp_port", {30'b0, bus.resp_valid_w_o}, 32'd1 << e.port);
                chk("resp_res",  bus.resp_res_w_o, e.res);
                chk("resp_zero", {31'b0, bus.resp_zero_w_o_h}, {31'b0, e.zero});
                chk("resp_err",  {31'b0, bus.resp_err_w_o_h}, {31'b0, e.err});
            end
        end
    end

    task automatic set_port(input int p, input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
        bus.req_a_w_i[32*p +: 32]   = a;
        bus.req_b_w_i[32*p +: 32]   = b;
        bus.req_ctrl_w_i[4*p +: 4]  = ctl;
    endtask

    task automatic wait_acc(input string name, input logic [1:0] want);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.req_ready_w_o == 2'b00 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(name, {30'b0, bus.req_ready_w_o}, {30'b0, want});
    endtask

    // One op on port p; hold = cycles resp_ready[p] is withheld while the other port requests.
    task automatic run_op(input int p, input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input logic err, input int hold);
        exp_t x;
        set_port(p, ctl, a, b);
        bus.req_valid_w_i[p] = 1'b1;
        bus.resp_ready_w_i   = (hold > 0) ? ((p == 0) ? 2'b10 : 2'b01) : 2'b11;
        wait_acc("accept_ready", 2'b01 << p);
        x.port = p; x.res = res; x.zero = (res == 32'd0); x.err = err;
        sbq.push_back(x);
        @(posedge clk); #1;
        bus.req_valid_w_i[p] = 1'b0;
        @(negedge clk);
        chk("exec_resp_valid", {30'b0, bus.resp_valid_w_o}, 32'd0);
        chk("exec_busy", {31'b0, bus.busy_w_o_h}, 32'd1);
        @(negedge clk);
        chk("t2_resp_valid", {30'b0, bus.resp_valid_w_o}, 32'd1 << p);
        if (hold > 0) begin
            set_port(1 - p, C_ADD, 32'd1, 32'd1);
            bus.req_valid_w_i[1-p] = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk("hold_valid", {30'b0, bus.resp_valid_w_o}, 32'd1 << p);
                chk("hold_res", bus.resp_res_w_o, res);
                chk("hold_err", {31'b0, bus.resp_err_w_o_h}, {31'b0, err});
                chk("hold_req_ready", {30'b0, bus.req_ready_w_o}, 32'd0);
                chk("hold_busy", {31'b0, bus.busy_w_o_h}, 32'd1);
            end
            @(posedge clk); #1;
            bus.resp_ready_w_i = 2'b11;
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.req_valid_w_i = 2'b00;
    endtask

    initial begin
        exp_t x;
        bus.req_valid_w_i = 2'b00;
        bus.req_a_w_i     = '0;
        bus.req_b_w_i     = '0;
        bus.req_ctrl_w_i  = '0;
        bus.resp_ready_w_i = 2'b11;

        // Reset values
        #3;
        chk("rst_req_ready", {30'b0, bus.req_ready_w_o}, 32'd0);
        chk("rst_resp_valid", {30'b0, bus.resp_valid_w_o}, 32'd0);
        chk("rst_res", bus.resp_res_w_o, 32'd0);
        chk("rst_zero", {31'b0, bus.resp_zero_w_o_h}, 32'd0);
        chk("rst_err", {31'b0, bus.resp_err_w_o_h}, 32'd0);
        chk("rst_busy", {31'b0, bus.busy_w_o_h}, 32'd0);
        chk("rst_cont_cnt", {16'b0, bus.cont_cnt_w_o}, 32'd0);
        chk("rst_op_cnt", {16'b0, bus.op_cnt_w_o}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Reset asserted while a response is pending aborts it
        bus.resp_ready_w_i = 2'b00;
        set_port(0, C_ADD, 32'd3, 32'd4);
        bus.req_valid_w_i = 2'b01;
        wait_acc("abort_accept", 2'b01);
        @(posedge clk); #1;
        bus.req_valid_w_i = 2'b00;
        @(negedge clk);
        @(negedge clk);
        chk("abort_pre_valid", {30'b0, bus.resp_valid_w_o}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_valid", {30'b0, bus.resp_valid_w_o}, 32'd0);
        chk("abort_busy", {31'b0, bus.busy_w_o_h}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_quiet", {30'b0, bus.resp_valid_w_o}, 32'd0);
        end
        chk("abort_idle", {31'b0, bus.busy_w_o_h}, 32'd0);
        @(posedge clk); #1;
        bus.resp_ready_w_i = 2'b11;

        // Contention: grants alternate starting at port 0
        set_port(0, C_ADD, 32'd10, 32'd20);
        set_port(1, C_SUB, 32'd5, 32'd7);
        bus.req_valid_w_i = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_acc("rr_grant", 2'b01 << (k % 2));
            x.port = k % 2;
            x.res  = (k % 2 == 0) ? 32'h0000_001E : 32'hFFFF_FFFE;
            x.zero = 1'b0;
            x.err  = 1'b0;
            sbq.push_back(x);
            @(posedge clk); #1;
            if (k == 3) bus.req_valid_w_i = 2'b00;
            @(negedge clk);
            @(negedge clk);
            @(posedge clk); #1;
        end
`ifdef ALU_ARB_PERF_EN
        chk("perf_op_cnt", {16'b0, bus.op_cnt_w_o}, 32'd4);
        chk("perf_cont_nonzero", {31'b0, bus.cont_cnt_w_o != 16'd0}, 32'd1);
`else
        chk("perf_op_cnt_off", {16'b0, bus.op_cnt_w_o}, 32'd0);
        chk("perf_cont_cnt_off", {16'b0, bus.cont_cnt_w_o}, 32'd0);
`endif

        // Wrap-around add held for three cycles
        run_op(0, C_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 3);

        // Signed/unsigned compare and shifts on port 1, logic ops on port 0
        run_op(1, C_SLT,  32'h8000_0000, 32'd1, 32'd1, 1'b0, 0);
        run_op(1, C_SLTU, 32'h8000_0000, 32'd1, 32'd0, 1'b0, 0);
        run_op(1, C_SRA,  32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 0);
        run_op(1, C_SLL,  32'h0000_0001, 32'd32, 32'd0, 1'b0, 0);
        run_op(1, C_SRL,  32'hF000_0000, 32'd4, 32'h0F00_0000, 1'b0, 0);
        run_op(0, C_XOR,  32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F, 1'b0, 0);
        run_op(0, C_OR,   32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0, 0);
        run_op(0, C_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 0);
        run_op(0, C_SUB,  32'd7, 32'd5, 32'd2, 1'b0, 0);

        // Illegal control codes
        run_op(0, 4'b1111, 32'h0000_1234, 32'h0000_5678, 32'd0, 1'b1, 5);
        run_op(1, 4'b1001, 32'd9, 32'd9, 32'd0, 1'b1, 0);

        repeat (3) @(negedge clk);
        chk("sb_empty", sbq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, bad=%0d", bad);
        $fatal(1);
    end
endmodule
